ser_shift_engine: RTL and testbench
===================================

Name: ser_shift_engine

Overview:
- Serial shift engine downstream of the programmable clock divider, in the same CLK_IN domain.
- Takes the divider's clock output as a rate reference. Detects its edges and shifts one DATA_W-bit word out on MOSI while capturing MISO.
- Drives a gated serial clock SCLK_O and chip select CS_N. Software-facing side is a START/BUSY/DONE handshake.

Parameters:
- DATA_W, 16, word length in bits; legal range 2..32.
- TMO_CYC, 1024, CLK_IN cycles without an SCLK_IN edge while busy before aborting with ERR; legal range 4..65535.

Ports:
- CLK_IN  input  1  system clock; same clock that drives the divider.
- RST_N  input  1  asynchronous active-low reset.
- SCLK_IN  input  1  divider output (divide value must be >=1; bypass mode produces no detectable edges).
- START  input  1  one-cycle request; accepted only when BUSY=0.
- DIN  input  DATA_W  word to transmit; sampled on the START cycle.
- ABORT  input  1  synchronous abort of the transfer in progress.
- MISO  input  1  serial data in.
- SCLK_O  output  1  gated serial clock.
- MOSI  output  1  serial data out.
- CS_N  output  1  chip select, active low.
- BUSY  output  1  high from the cycle after START until return to IDLE.
- DONE  output  1  one-cycle pulse on successful completion.
- ERR  output  1  one-cycle pulse on timeout.
- DOUT  output  DATA_W  last completed received word.

Behaviour:
- Reset (RST_N=0, async): state IDLE, SCLK_O=0, MOSI=0, CS_N=1, BUSY=0, DONE=0, ERR=0, DOUT=0, all internal counters and registers 0.
- Edge detect: sclk_q <= SCLK_IN each cycle. rise = SCLK_IN & ~sclk_q; fall = ~SCLK_IN & sclk_q. Acting on an edge takes one CLK_IN cycle.
- IDLE:
  - START=1: latch DIN into tx shift register, bitcnt <= DATA_W, CS_N <= 0, BUSY <= 1, MOSI <= first bit, go SETUP.
  - START while BUSY=1 is ignored; no queuing.
- SETUP: wait for the next fall, then go SHIFT. Ensures the first bit gets a full low phase of setup.
- SHIFT:
  - SCLK_O follows sclk_q.
  - On rise: rx <= {rx[DATA_W-2:0], MISO}.
  - On fall with bitcnt==1: go TRAIL and force SCLK_O <= 0.
  - On fall otherwise: shift tx, MOSI <= next bit, bitcnt <= bitcnt-1.
- TRAIL: SCLK_O=0, CS_N held low until the next rise (half-period CS hold), then go FINISH.
- FINISH (1 cycle): DOUT <= rx, DONE=1, CS_N <= 1, BUSY <= 0, MOSI <= 0, go IDLE.
  - START arriving in the FINISH cycle is ignored.
  - START on the first IDLE cycle after FINISH is accepted.
- ABORT: in any non-IDLE state, go IDLE next cycle with CS_N=1, SCLK_O=0, BUSY=0. No DONE, no ERR, DOUT unchanged. ABORT in IDLE has no effect. ABORT has priority over START and over edge actions in the same cycle.
- Timeout:
  - tmo counter clears on any rise/fall and in IDLE; otherwise increments while BUSY.
  - On reaching TMO_CYC-1: ERR pulse, behave as ABORT (DOUT unchanged).
  - ABORT and timeout in the same cycle: ABORT wins, ERR=0.
- SCLK_IN edge coincident with the START cycle is ignored; SETUP waits for the following fall.
- RST_N assertion mid-transfer: immediate return to reset values.

Optional Feature:
- SER_LSB_FIRST_EN
  - Defined: transmit DIN[0] first, shift tx right. Received bits enter at rx[DATA_W-1] and shift right, so DOUT bit order mirrors DIN.
  - Undefined: MSB first (DIN[DATA_W-1] first), rx shifts left. All timing identical.

Test Plan:
- DATA_W=16, divider value 2 (SCLK_IN period 4 CLK_IN), DIN=16'hA5C3, MISO looped to MOSI:
  - MOSI bit sequence 1010_0101_1100_0011.
  - Exactly 16 SCLK_O rising edges.
  - DONE one cycle, DOUT=16'hA5C3, CS_N high the cycle after DONE.
- START with DIN=16'h1234 while BUSY -> ignored: DOUT equals the first word, MOSI stream unaffected.
- ABORT asserted after 5 SCLK_O rises -> next cycle CS_N=1, BUSY=0, SCLK_O=0. No DONE/ERR, DOUT keeps prior value.
- TMO_CYC=8, SCLK_IN held low after START -> ERR pulse 8 cycles after the last edge, CS_N=1, BUSY=0, DONE never asserted.
- SER_LSB_FIRST_EN defined, DIN=16'h0001, loopback -> MOSI high on first bit only, DOUT=16'h0001.
- RST_N pulsed low mid-SHIFT -> all outputs at reset values asynchronously. A new START after release completes normally.

Source files
------------

// File: rtl/ser_shift_engine.sv
// ser_shift_engine: serial shift engine clocked by CLK_IN, paced by the
// divider output on SCLK_IN. Shifts one DATA_W-bit word out on MOSI while
// capturing MISO. It drives a gated SCLK_O and CS_N and uses a
// START/BUSY/DONE handshake. ERR pulses when SCLK_IN stops toggling
// mid-transfer.
// Optional build macro SER_LSB_FIRST_EN: LSB-first transmit, and received
// bits enter at the MSB and shift right. MSB-first when it is undefined.
module ser_shift_engine #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic              CLK_IN,
    input  logic              RST_N,
    input  logic              SCLK_IN,
    input  logic              START,
    input  logic [DATA_W-1:0] DIN,
    input  logic              ABORT,
    input  logic              MISO,
    output logic              SCLK_O,
    output logic              MOSI,
    output logic              CS_N,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [DATA_W-1:0] DOUT
);

    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_TRAIL,
        S_FINISH
    } state_t;

    state_t            state;
    logic              sclk_q;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic [CNT_W-1:0]  bitcnt;
    logic [TMO_W-1:0]  tmo;

    logic              rise;
    logic              fall;
    logic              edge_any;
    logic [TMO_W-1:0]  tmo_nxt;
    logic              tmo_hit;
    logic              first_bit;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_shifted;
    logic              tx_next_bit;

    // Edge detect on the divider output, timeout increment and bit-order steering
    always_comb begin
        rise     = SCLK_IN & ~sclk_q;
        fall     = ~SCLK_IN & sclk_q;
        edge_any = rise | fall;
        tmo_nxt  = tmo + 1'b1;
        tmo_hit  = (tmo_nxt == TMO_W'(TMO_CYC - 1));
`ifdef SER_LSB_FIRST_EN
        first_bit   = DIN[0];
        // rotate rather than zero-fill: bitcnt alone ends the word
        tx_shifted  = {tx[0], tx[DATA_W-1:1]};
        rx_shifted  = {MISO, rx[DATA_W-1:1]};
        tx_next_bit = tx_shifted[0];
`else
        first_bit   = DIN[DATA_W-1];
        tx_shifted  = {tx[DATA_W-2:0], tx[DATA_W-1]};
        rx_shifted  = {rx[DATA_W-2:0], MISO};
        tx_next_bit = tx_shifted[DATA_W-1];
`endif
    end

    // Transfer FSM with registered serial outputs and handshake
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            sclk_q <= 1'b0;
            tx     <= '0;
            rx     <= '0;
            bitcnt <= '0;
            tmo    <= '0;
            SCLK_O <= 1'b0;
            MOSI   <= 1'b0;
            CS_N   <= 1'b1;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
            DOUT   <= '0;
        end else begin
            sclk_q <= SCLK_IN;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
            if (state == S_IDLE) begin
                tmo <= '0;
                // edges coincident with START are not acted on
                if (START) begin
                    tx     <= DIN;
                    bitcnt <= CNT_W'(DATA_W);
                    CS_N   <= 1'b0;
                    BUSY   <= 1'b1;
                    MOSI   <= first_bit;
                    state  <= S_SETUP;
                end
            end else if (ABORT || (!edge_any && tmo_hit)) begin
                // abort and timeout share one exit; ABORT suppresses ERR
                state  <= S_IDLE;
                CS_N   <= 1'b1;
                SCLK_O <= 1'b0;
                BUSY   <= 1'b0;
                MOSI   <= 1'b0;
                tmo    <= '0;
                ERR    <= ~ABORT;
            end else begin
                tmo <= edge_any ? '0 : tmo_nxt;
                case (state)
                    S_SETUP: begin
                        if (fall) begin
                            state <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        // next sclk_q value, so SCLK_O tracks sclk_q
                        SCLK_O <= SCLK_IN;
                        if (rise) begin
                            rx <= rx_shifted;
                        end
                        if (fall) begin
                            if (bitcnt == CNT_W'(1)) begin
                                state  <= S_TRAIL;
                                SCLK_O <= 1'b0;
                            end else begin
                                tx     <= tx_shifted;
                                MOSI   <= tx_next_bit;
                                bitcnt <= bitcnt - 1'b1;
                            end
                        end
                    end
                    S_TRAIL: begin
                        SCLK_O <= 1'b0;
                        // DONE is raised here so it is high during FINISH
                        if (rise) begin
                            state <= S_FINISH;
                            DOUT  <= rx;
                            DONE  <= 1'b1;
                        end
                    end
                    S_FINISH: begin
                        CS_N  <= 1'b1;
                        BUSY  <= 1'b0;
                        MOSI  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_shift_engine.sv
// Testbench for ser_shift_engine. A behavioural divider drives SCLK_IN.
// A monitor logs MOSI on every SCLK_O rise. The bench drives MISO from a
// reference word, or from MOSI when loopback is selected. Expected words,
// edge counts and timeout latency come from the transfer rules, not from
// the RTL.
module tb_ser_shift_engine;

    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 8;

    logic         CLK_IN  = 1'b0;
    logic         RST_N   = 1'b0;
    logic         SCLK_IN = 1'b0;
    logic         START   = 1'b0;
    logic [W-1:0] DIN     = '0;
    logic         ABORT   = 1'b0;
    logic         MISO;
    logic         SCLK_O;
    logic         MOSI;
    logic         CS_N;
    logic         BUSY;
    logic         DONE;
    logic         ERR;
    logic [W-1:0] DOUT;

    ser_shift_engine #(.DATA_W(W), .TMO_CYC(TMO)) dut (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .SCLK_IN(SCLK_IN),
        .START  (START),
        .DIN    (DIN),
        .ABORT  (ABORT),
        .MISO   (MISO),
        .SCLK_O (SCLK_O),
        .MOSI   (MOSI),
        .CS_N   (CS_N),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR),
        .DOUT   (DOUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    // behavioural divider: toggles every hp CLK_IN cycles, parks low when stopped
    int hp = 2;
    bit sclk_run = 1'b1;
    int last_edge = 0;
    initial begin
        forever begin
            for (int i = 0; i < hp; i++) begin
                @(posedge CLK_IN);
                #1;
            end
            if (sclk_run) begin
                SCLK_IN = ~SCLK_IN;
                last_edge = cyc;
            end else if (SCLK_IN) begin
                SCLK_IN = 1'b0;
                last_edge = cyc;
            end
        end
    end

    // monitor
    bit   mosi_log[$];
    int   rise_cnt = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    logic sclk_prev = 1'b0;
    always @(negedge CLK_IN) begin
        if (!sclk_prev && SCLK_O === 1'b1) begin
            mosi_log.push_back(MOSI);
            rise_cnt = rise_cnt + 1;
        end
        sclk_prev = SCLK_O;
        if (DONE === 1'b1) done_cnt = done_cnt + 1;
        if (ERR === 1'b1) err_cnt = err_cnt + 1;
    end

    // wire order of the word: position k on the wire carries this bit index
    function automatic int bit_pos(input int k);
`ifdef SER_LSB_FIRST_EN
        return k;
`else
        return int'(W) - 1 - k;
`endif
    endfunction

    // slave model: presents bit k of rx_word before the k-th SCLK_O rise
    int           base = 0;
    logic [W-1:0] rx_word = '0;
    bit           lb = 1'b0;
    int           miso_k;
    always_comb begin
        miso_k = rise_cnt - base;
        if (miso_k < 0 || miso_k >= int'(W)) miso_k = 0;
        MISO = lb ? MOSI : rx_word[bit_pos(miso_k)];
    end

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] exp_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge CLK_IN);
        #1;
    endtask

    task automatic issue_start(input logic [W-1:0] tw, input logic [W-1:0] rw,
                               input bit loop, output int s_cyc);
        int g;
        g = 0;
        while (BUSY && g < 500) begin
            tick();
            g++;
        end
        chk("idle_before_start", 32'(BUSY), 32'd0);
        DIN     = tw;
        START   = 1'b1;
        base    = rise_cnt;
        rx_word = rw;
        lb      = loop;
        s_cyc   = cyc;
        tick();
        START = 1'b0;
        DIN   = W'($urandom);
        chk("busy_after_start", 32'(BUSY), 32'd1);
    endtask

    task automatic wait_rises(input int n);
        int g;
        g = 0;
        while ((rise_cnt - base) < n && g < 500) begin
            tick();
            g++;
        end
        chk("rises_reached", 32'((rise_cnt - base) >= n), 32'd1);
    endtask

    task automatic wait_done(input logic [W-1:0] tw, input logic [W-1:0] rw_exp,
                             input bit inj, input bit chain, input logic [W-1:0] nxt);
        int g, d0;
        bit seen, injected;
        logic [W-1:0] obs;
        d0 = done_cnt;
        seen = 1'b0;
        injected = 1'b0;
        for (g = 0; g < 600 && !seen; g++) begin
            if (inj && !injected && (rise_cnt - base) >= 4) begin
                DIN = 16'h1234;
                START = 1'b1;
                injected = 1'b1;
            end
            tick();
            START = 1'b0;
            seen = (DONE === 1'b1);
        end
        chk("done_seen", 32'(seen), 32'd1);
        obs = '0;
        for (int k = 0; k < int'(W); k++)
            if (base + k < mosi_log.size()) obs[bit_pos(k)] = mosi_log[base + k];
        chk("mosi_word", 32'(obs), 32'(tw));
        chk("sclk_rises", 32'(rise_cnt - base), 32'(W));
        chk("dout", 32'(DOUT), 32'(rw_exp));
        chk("cs_low_at_done", 32'(CS_N), 32'd0);
        if (chain) begin
            DIN = nxt;
            START = 1'b1;
        end
        tick();
        chk("done_one_cycle", 32'(DONE), 32'd0);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("cs_high_after_done", 32'(CS_N), 32'd1);
        chk("busy_low_after_done", 32'(BUSY), 32'd0);
        exp_dout = rw_exp;
    endtask

    task automatic run_timeout(input bit mid);
        int s, g, e0, d0, ref_c;
        bit seen;
        logic [W-1:0] tw, rw;
        e0 = err_cnt;
        d0 = done_cnt;
        tw = W'($urandom);
        rw = W'($urandom);
        if (!mid) begin
            sclk_run = 1'b0;
            g = 0;
            while (SCLK_IN && g < 20) begin
                tick();
                g++;
            end
            tick();
        end
        issue_start(tw, rw, 1'b0, s);
        if (mid) begin
            wait_rises(3);
            sclk_run = 1'b0;
        end
        seen = 1'b0;
        for (g = 0; g < 200 && !seen; g++) begin
            tick();
            seen = (ERR === 1'b1);
        end
        chk("err_seen", 32'(seen), 32'd1);
        ref_c = (last_edge > s) ? last_edge : s;
        chk("err_latency", 32'(cyc - ref_c), 32'(TMO));
        chk("err_cs_n", 32'(CS_N), 32'd1);
        chk("err_busy", 32'(BUSY), 32'd0);
        chk("err_sclk_o", 32'(SCLK_O), 32'd0);
        chk("err_dout_kept", 32'(DOUT), 32'(exp_dout));
        tick();
        chk("err_one_cycle", 32'(ERR), 32'd0);
        chk("err_count", 32'(err_cnt - e0), 32'd1);
        chk("err_no_done", 32'(done_cnt - d0), 32'd0);
        sclk_run = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int s, d0, e0;
        logic [W-1:0] tw, rw, w2;
        bit loop, inj;

        repeat (3) tick();
        chk("rst_outs", 32'({SCLK_O, MOSI, CS_N, BUSY, DONE, ERR}), 32'(6'b001000));
        chk("rst_dout", 32'(DOUT), 32'd0);
        RST_N = 1'b1;
        repeat (2) tick();

        // directed loopback word at divider value 2, plus an ignored START while busy
        hp = 2;
        issue_start(16'hA5C3, '0, 1'b1, s);
        wait_done(16'hA5C3, 16'hA5C3, 1'b1, 1'b0, '0);

        // START held through FINISH and the first IDLE cycle: only the IDLE one counts
        w2 = 16'h3C5A;
        issue_start(16'h0F0F, 16'hBEEF, 1'b0, s);
        wait_done(16'h0F0F, 16'hBEEF, 1'b0, 1'b1, w2);
        base    = rise_cnt;
        rx_word = 16'h8001;
        lb      = 1'b0;
        tick();
        START = 1'b0;
        chk("b2b_accepted", 32'(BUSY), 32'd1);
        wait_done(w2, 16'h8001, 1'b0, 1'b0, '0);

        // randomized transfers
        for (int it = 0; it < 8; it++) begin
            hp   = $urandom_range(2, 3);
            tw   = W'($urandom);
            rw   = W'($urandom);
            loop = 1'($urandom_range(0, 1));
            inj  = 1'($urandom_range(0, 1));
            issue_start(tw, rw, loop, s);
            wait_done(tw, loop ? tw : rw, inj, 1'b0, '0);
        end

        // single set bit, loopback
        hp = 2;
        issue_start(16'h0001, '0, 1'b1, s);
        wait_done(16'h0001, 16'h0001, 1'b0, 1'b0, '0);

        // abort after five SCLK_O rises
        d0 = done_cnt;
        e0 = err_cnt;
        issue_start(16'hFFFF, 16'h5555, 1'b0, s);
        wait_rises(5);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_cs_n", 32'(CS_N), 32'd1);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_sclk_o", 32'(SCLK_O), 32'd0);
        repeat (20) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_no_err", 32'(err_cnt - e0), 32'd0);
        chk("abort_dout_kept", 32'(DOUT), 32'(exp_dout));

        // timeouts: no edge at all after START, and divider stalling mid-word
        run_timeout(1'b0);
        run_timeout(1'b1);
        repeat (4) tick();

        // async reset mid-shift, then a clean transfer
        issue_start(16'h6789, 16'h1357, 1'b0, s);
        wait_rises(6);
        RST_N = 1'b0;
        #1;
        chk("rst_mid_outs", 32'({SCLK_O, MOSI, CS_N, BUSY, DONE, ERR}), 32'(6'b001000));
        chk("rst_mid_dout", 32'(DOUT), 32'd0);
        exp_dout = '0;
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (2) tick();
        tw = W'($urandom);
        rw = W'($urandom);
        issue_start(tw, rw, 1'b0, s);
        wait_done(tw, rw, 1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
